window_feeder_2x2: RTL and testbench

WINDOW_FEEDER_2X2 -- requirements
Module: window_feeder_2x2

---
 rtl/window_feeder_2x2.sv | 111 +++++++++++
 tb/tb_window_feeder_2x2.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/window_feeder_2x2.sv
// 2x2 sliding-window feeder: raster pixels in, one window per pixel at row>=1, col>=1.
// Ports: clk, rst (async active-low), in_* stream in, A..D/win_* window out.
module window_feeder_2x2 #(
  parameter int IMG_WIDTH  = 16,
  parameter int IMG_HEIGHT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_sof,
  input  logic [7:0] in_pixel,
  output logic       in_ready,
  output logic [7:0] A,
  output logic [7:0] B,
  output logic [7:0] C,
  output logic [7:0] D,
  output logic       win_valid,
  output logic       win_last,
  input  logic       win_ready
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] LAST_C = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_R = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [7:0]    r_top_prev;
  logic [7:0]    r_cur_prev;
  logic [7:0]    r_lb [IMG_WIDTH];
  logic [7:0]    r_a, r_b, r_c, r_d;
  logic          r_wv;
  logic          r_wl;

  logic          w_acc;
  logic [CW-1:0] w_c;
  logic [RW-1:0] w_r;
  logic [CW-1:0] w_c_nxt;
  logic [RW-1:0] w_r_nxt;
  logic [7:0]    w_old;
  logic          w_win;
  logic          w_last;

  assign in_ready = !r_wv || win_ready;
  assign w_acc    = in_valid && in_ready;

  // in_sof overrides the counters so a new frame always starts at (0,0)
  assign w_c   = in_sof ? '0 : r_col;
  assign w_r   = in_sof ? '0 : r_row;
  assign w_old = r_lb[w_c];

  always_comb begin
    w_c_nxt = w_c + CW'(1);
    w_r_nxt = w_r;
    if (w_c == LAST_C) begin
      w_c_nxt = '0;
      w_r_nxt = (w_r == LAST_R) ? '0 : w_r + RW'(1);
    end
  end

  assign w_win  = w_acc && (w_r != '0) && (w_c != '0);
  assign w_last = (w_r == LAST_R) && (w_c == LAST_C);

  // line buffer has no reset; a frame never reads a row it has not written
  always_ff @(posedge clk) begin
    if (w_acc) r_lb[w_c] <= in_pixel;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col      <= '0;
      r_row      <= '0;
      r_top_prev <= '0;
      r_cur_prev <= '0;
    end else if (w_acc) begin
      r_col      <= w_c_nxt;
      r_row      <= w_r_nxt;
      r_top_prev <= w_old;
      r_cur_prev <= in_pixel;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a  <= '0;
      r_b  <= '0;
      r_c  <= '0;
      r_d  <= '0;
      r_wv <= 1'b0;
      r_wl <= 1'b0;
    end else begin
      r_wv <= w_win || (r_wv && !win_ready);
      if (w_win) begin
        r_a  <= r_top_prev;
        r_b  <= w_old;
        r_c  <= r_cur_prev;
        r_d  <= in_pixel;
        r_wl <= w_last;
      end
    end
  end

  assign A         = r_a;
  assign B         = r_b;
  assign C         = r_c;
  assign D         = r_d;
  assign win_valid = r_wv;
  assign win_last  = r_wl;

endmodule

// File: tb/tb_window_feeder_2x2.sv
// Randomised bench for window_feeder_2x2 against a frame-array reference model.
// Model stores each frame pixel by (row,col) and queues the expected windows.
module tb_window_feeder_2x2;

  localparam int W = 4;
  localparam int H = 3;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] d;
    logic       last;
  } win_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_sof;
  logic [7:0] in_pixel;
  logic       in_ready;
  logic [7:0] A, B, C, D;
  logic       win_valid;
  logic       win_last;
  logic       win_ready;

  window_feeder_2x2 #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .in_pixel (in_pixel),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .C        (C),
    .D        (D),
    .win_valid(win_valid),
    .win_last (win_last),
    .win_ready(win_ready)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   npop   = 0;
  win_t q[$];
  int   mf [H][W];
  int   mr = 0;
  int   mc = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic s, input logic wr,
                      input logic [7:0] p);
    logic acc;
    logic mrdy;
    win_t w;
    in_valid  = v;
    in_sof    = s;
    in_pixel  = p;
    win_ready = wr;
    #1;
    mrdy = (q.size() == 0) || wr;
    check("in_ready", in_ready, mrdy);
    check("win_valid", win_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("A", A, q[0].a);
      check("B", B, q[0].b);
      check("C", C, q[0].c);
      check("D", D, q[0].d);
      check("win_last", win_last, q[0].last);
    end
    acc = v && mrdy;
    if (q.size() != 0 && wr) begin
      void'(q.pop_front());
      npop++;
    end
    if (acc) begin
      if (s) begin
        mr = 0;
        mc = 0;
      end
      mf[mr][mc] = p;
      if (mr >= 1 && mc >= 1) begin
        w.a    = 8'(mf[mr-1][mc-1]);
        w.b    = 8'(mf[mr-1][mc]);
        w.c    = 8'(mf[mr][mc-1]);
        w.d    = p;
        w.last = (mr == H-1) && (mc == W-1);
        q.push_back(w);
      end
      mc++;
      if (mc == W) begin
        mc = 0;
        mr = (mr == H-1) ? 0 : mr + 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_wv", win_valid, 1'b0);
    check("rst_wl", win_last, 1'b0);
    check("rst_abcd", {A, B, C, D}, 32'h0);
    check("rst_rdy", in_ready, 1'b1);
    q.delete();
    mr = 0;
    mc = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int base;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_pixel  = '0;
    win_ready = 1'b1;
    rst       = 1'b1;
    @(negedge clk);
    do_reset();

    base = npop;
    for (int i = 0; i < 12; i++) step(1'b1, i == 0, 1'b1, 8'(i));
    step(1'b0, 1'b0, 1'b1, 8'h0);
    step(1'b0, 1'b0, 1'b1, 8'h0);
    check("nwin_frame", npop - base, 6);

    for (int i = 0; i < 6; i++) step(1'b1, i == 0, 1'b1, 8'(i));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'(6));
    for (int i = 6; i < 12; i++) step(1'b1, 1'b0, 1'b1, 8'(i));
    step(1'b0, 1'b0, 1'b1, 8'h0);

    for (int i = 0; i < 7; i++) step(1'b1, i == 0, 1'b1, 8'(i));
    for (int i = 0; i < 12; i++) step(1'b1, i == 0, 1'b1, 8'(100 + i));
    step(1'b0, 1'b0, 1'b1, 8'h0);

    base = npop;
    for (int i = 0; i < 24; i++)
      step(i % 2 == 0, i == 0, 1'b1, 8'(i / 2));
    step(1'b0, 1'b0, 1'b1, 8'h0);
    step(1'b0, 1'b0, 1'b1, 8'h0);
    check("nwin_toggle", npop - base, 6);

    for (int i = 0; i < 6; i++) step(1'b1, i == 0, 1'b1, 8'(i));
    check("pend_before_rst", win_valid, 1'b1);
    do_reset();

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else step($urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0,
                $urandom_range(0, 9) < 7, 8'($urandom));
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
